// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_pkg                                                              |
// | Shared bus field encodings and arbiter state type.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bus_pkg;

   localparam int c_addr_w = 32;
   localparam int c_data_w = 32;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } ttype_t;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } tsize_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      XFER = 2'd2
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2                                                          |
// | Combinational two-way round-robin pick; ties go to the other master. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_pick,
   output logic       o_valid
);

   assign o_valid = |i_req;
   assign o_pick  = (&i_req) ? ~i_last : i_req[1];

endmodule
`default_nettype wire

// File: rtl/ibus_dbus_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ibus_dbus_mem_arbiter                                                |
// | Shares memory slave s0 between ibus (m0) and dbus (m1) masters.      |
// | Optional slave timeout: define ARB_TIMEOUT_EN.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ibus_dbus_mem_arbiter
   import bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_m0_breq,
   input  logic                i_m0_bstart,
   input  logic [c_addr_w-1:0] i_m0_addr,
   input  logic [c_data_w-1:0] i_m0_wdata,
   input  logic                i_m0_ttype,
   input  logic [1:0]          i_m0_tsize,
   output logic                o_m0_bgnt,
   output logic                o_m0_bdone,
   output logic [c_data_w-1:0] o_m0_rdata,
   output logic                o_m0_berror,
   input  logic                i_m1_breq,
   input  logic                i_m1_bstart,
   input  logic [c_addr_w-1:0] i_m1_addr,
   input  logic [c_data_w-1:0] i_m1_wdata,
   input  logic                i_m1_ttype,
   input  logic [1:0]          i_m1_tsize,
   output logic                o_m1_bgnt,
   output logic                o_m1_bdone,
   output logic [c_data_w-1:0] o_m1_rdata,
   output logic                o_m1_berror,
   output logic                o_s0_ss,
   output logic                o_s0_bstart,
   output logic [c_addr_w-1:0] o_s0_addr,
   output logic [c_data_w-1:0] o_s0_wdata,
   output logic                o_s0_ttype,
   output logic [1:0]          o_s0_tsize,
   input  logic                i_s0_bdone,
   input  logic [c_data_w-1:0] i_s0_rdata
);

   arb_state_t          r_state, w_state_nxt;
   logic                r_owner, w_owner_nxt;
   logic                r_last, w_last_nxt;
   logic                w_pick, w_any;
   logic                w_own_breq, w_own_bstart, w_oth_breq;
   logic [c_addr_w-1:0] w_own_addr;
   logic [c_data_w-1:0] w_own_wdata;
   logic                w_own_ttype;
   logic [1:0]          w_own_tsize;
   logic                w_timeout;
   logic                w_active, w_xfer, w_done, w_err;
   logic [c_data_w-1:0] w_rdata;

   rr_arbiter2 u_rr (
      .i_req   ({i_m1_breq, i_m0_breq}),
      .i_last  (r_last),
      .o_pick  (w_pick),
      .o_valid (w_any)
   );

   assign w_own_breq   = r_owner ? i_m1_breq   : i_m0_breq;
   assign w_own_bstart = r_owner ? i_m1_bstart : i_m0_bstart;
   assign w_oth_breq   = r_owner ? i_m0_breq   : i_m1_breq;
   assign w_own_addr   = r_owner ? i_m1_addr   : i_m0_addr;
   assign w_own_wdata  = r_owner ? i_m1_wdata  : i_m0_wdata;
   assign w_own_ttype  = r_owner ? i_m1_ttype  : i_m0_ttype;
   assign w_own_tsize  = r_owner ? i_m1_tsize  : i_m0_tsize;

`ifdef ARB_TIMEOUT_EN
   localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (r_state == OWN && w_own_bstart) begin
         r_to_cnt <= '0;
      end else if (r_state == XFER && !i_s0_bdone) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // A real bdone in the expiry cycle takes priority over the error.
   assign w_timeout = (r_state == XFER) && !i_s0_bdone && (r_to_cnt == c_to_last);
`else
   localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
   logic w_unused_to;
   assign w_unused_to = ^c_to_last;
   assign w_timeout   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = OWN;
               w_owner_nxt = w_pick;
            end
         end
         OWN: begin
            if (w_own_bstart) begin
               w_state_nxt = XFER;
            end else if (!w_own_breq) begin
               w_state_nxt = IDLE;
               w_last_nxt  = r_owner;
            end
         end
         XFER: begin
            if (i_s0_bdone) begin
               w_last_nxt = r_owner;
               // A waiting peer forces re-arbitration before a back-to-back.
               if (w_oth_breq)      w_state_nxt = IDLE;
               else if (w_own_breq) w_state_nxt = OWN;
               else                 w_state_nxt = IDLE;
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
               w_last_nxt  = r_owner;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_active = (r_state != IDLE);
   assign w_xfer   = (r_state == XFER);
   assign w_done   = w_xfer && (i_s0_bdone || w_timeout);
   assign w_err    = w_xfer && w_timeout;
   assign w_rdata  = (w_xfer && i_s0_bdone) ? i_s0_rdata : '0;

   assign o_s0_ss     = w_active && !w_timeout;
   assign o_s0_bstart = (r_state == OWN) && w_own_bstart;
   assign o_s0_addr   = w_active ? w_own_addr  : '0;
   assign o_s0_wdata  = w_active ? w_own_wdata : '0;
   assign o_s0_ttype  = w_active ? w_own_ttype : 1'(READ);
   assign o_s0_tsize  = w_active ? w_own_tsize : 2'(WORD);

   assign o_m0_bgnt   = w_active && !r_owner;
   assign o_m0_bdone  = w_done   && !r_owner;
   assign o_m0_berror = w_err    && !r_owner;
   assign o_m0_rdata  = r_owner ? '0 : w_rdata;
   assign o_m1_bgnt   = w_active && r_owner;
   assign o_m1_bdone  = w_done   && r_owner;
   assign o_m1_berror = w_err    && r_owner;
   assign o_m1_rdata  = r_owner ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ibus_dbus_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ibus_dbus_mem_arbiter                                             |
// | Vector table, directed corner sequences and randomized traffic.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ibus_dbus_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int TB_TO = 8;
`else
   localparam int TB_TO = 255;
`endif
   localparam logic [31:0] A0  = 32'hF000_0010;
   localparam logic [31:0] A1  = 32'h1000_0020;
   localparam logic [31:0] W0  = 32'h0000_AAAA;
   localparam logic [31:0] W1  = 32'h5555_0000;
   localparam logic [31:0] KEY = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_breq, m0_bstart, m0_ttype, m0_bgnt, m0_bdone, m0_berror;
   logic [1:0]  m0_tsize;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_breq, m1_bstart, m1_ttype, m1_bgnt, m1_bdone, m1_berror;
   logic [1:0]  m1_tsize;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        s0_ss, s0_bstart, s0_ttype, s0_bdone;
   logic [1:0]  s0_tsize;
   logic [31:0] s0_addr, s0_wdata, s0_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ibus_dbus_mem_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
      .clk(clk), .rst(rst),
      .i_m0_breq(m0_breq), .i_m0_bstart(m0_bstart), .i_m0_addr(m0_addr),
      .i_m0_wdata(m0_wdata), .i_m0_ttype(m0_ttype), .i_m0_tsize(m0_tsize),
      .o_m0_bgnt(m0_bgnt), .o_m0_bdone(m0_bdone), .o_m0_rdata(m0_rdata),
      .o_m0_berror(m0_berror),
      .i_m1_breq(m1_breq), .i_m1_bstart(m1_bstart), .i_m1_addr(m1_addr),
      .i_m1_wdata(m1_wdata), .i_m1_ttype(m1_ttype), .i_m1_tsize(m1_tsize),
      .o_m1_bgnt(m1_bgnt), .o_m1_bdone(m1_bdone), .o_m1_rdata(m1_rdata),
      .o_m1_berror(m1_berror),
      .o_s0_ss(s0_ss), .o_s0_bstart(s0_bstart), .o_s0_addr(s0_addr),
      .o_s0_wdata(s0_wdata), .o_s0_ttype(s0_ttype), .o_s0_tsize(s0_tsize),
      .i_s0_bdone(s0_bdone), .i_s0_rdata(s0_rdata)
   );

   typedef struct packed {
      logic       rst, b0, st0, b1, st1, bd;
      logic [1:0] g;
      logic       ss, sb;
      logic [1:0] d;
   } vec_t;

   vec_t tv [30];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clr();
      m0_breq = 0; m0_bstart = 0; m1_breq = 0; m1_bstart = 0; s0_bdone = 0;
   endtask

   // Randomized-traffic model state: per-master transaction phase and one slave.
   int          ph [2];
   logic [31:0] ma [2], mw [2];
   logic        mt [2];
   logic [1:0]  ms [2];
   logic        bst [2], breq_d [2];
   logic        sl_busy, sl_fire, sl_who;
   int          sl_cnt, exp_next, issued, done_n;
   logic [31:0] sl_addr;

   task automatic newtxn(input int i);
      ma[i] = $urandom() & 32'hFFFF_FFFC;
      mw[i] = $urandom();
      mt[i] = 1'($urandom_range(0, 1));
      ms[i] = 2'($urandom_range(0, 2));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] ea, ew;
      logic        et;
      logic [1:0]  es, bdv, bgv, erv;
      logic [31:0] rdv [2];

      //        rst b0 st0 b1 st1 bd   g     ss sb  d
      tv[0]  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[1]  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[2]  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b1,2'b00};
      tv[3]  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,2'b00};
      tv[4]  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,2'b00};
      tv[5]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b01,1'b1,1'b0,2'b01};
      tv[6]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[7]  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[8]  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[9]  = {1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 2'b01,1'b1,1'b1,2'b00};
      tv[10] = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 2'b01,1'b1,1'b0,2'b01};
      tv[11] = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[12] = {1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b10,1'b1,1'b1,2'b00};
      tv[13] = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 2'b10,1'b1,1'b0,2'b10};
      tv[14] = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[15] = {1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 2'b01,1'b1,1'b1,2'b00};
      tv[16] = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 2'b01,1'b1,1'b0,2'b01};
      tv[17] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,2'b00};
      tv[18] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[19] = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[20] = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b01,1'b1,1'b0,2'b00};
      tv[21] = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[22] = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b10,1'b1,1'b0,2'b00};
      tv[23] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,2'b00};
      tv[24] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[25] = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};
      tv[26] = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b1,2'b00};
      tv[27] = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,2'b00};
      tv[28] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,1'b0,1'b0,2'b00};
      tv[29] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,2'b00};

      rst = 1; clr();
      m0_addr = A0; m0_wdata = W0; m0_ttype = 1'b0; m0_tsize = 2'd2;
      m1_addr = A1; m1_wdata = W1; m1_ttype = 1'b1; m1_tsize = 2'd1;
      s0_rdata = 32'hDEAD_BEEF;
      repeat (3) tick();

      for (int k = 0; k < 30; k++) begin
         tick();
         rst = tv[k].rst; m0_breq = tv[k].b0; m0_bstart = tv[k].st0;
         m1_breq = tv[k].b1; m1_bstart = tv[k].st1; s0_bdone = tv[k].bd;
         settle();
         ea = tv[k].g[0] ? A0 : (tv[k].g[1] ? A1 : 32'h0);
         ew = tv[k].g[0] ? W0 : (tv[k].g[1] ? W1 : 32'h0);
         et = tv[k].g[1];
         es = tv[k].g[1] ? 2'd1 : 2'd2;
         chk($sformatf("v%0d m0_bgnt", k), m0_bgnt, tv[k].g[0]);
         chk($sformatf("v%0d m1_bgnt", k), m1_bgnt, tv[k].g[1]);
         chk($sformatf("v%0d s0_ss", k), s0_ss, tv[k].ss);
         chk($sformatf("v%0d s0_bstart", k), s0_bstart, tv[k].sb);
         chk($sformatf("v%0d m0_bdone", k), m0_bdone, tv[k].d[0]);
         chk($sformatf("v%0d m1_bdone", k), m1_bdone, tv[k].d[1]);
         chk($sformatf("v%0d m0_rdata", k), m0_rdata, tv[k].d[0] ? 32'hDEAD_BEEF : 32'h0);
         chk($sformatf("v%0d m1_rdata", k), m1_rdata, tv[k].d[1] ? 32'hDEAD_BEEF : 32'h0);
         chk($sformatf("v%0d s0_addr", k), s0_addr, ea);
         chk($sformatf("v%0d s0_wdata", k), s0_wdata, ew);
         chk($sformatf("v%0d s0_ttype", k), s0_ttype, et);
         chk($sformatf("v%0d s0_tsize", k), s0_tsize, es);
         chk($sformatf("v%0d berror", k), {m1_berror, m0_berror}, 0);
      end

      // m1 back-to-back writes: the grant must never lapse between them.
      tick(); clr(); m1_breq = 1; m1_addr = 32'h2000_0100; settle();
      chk("b2b first idle bgnt", m1_bgnt, 0);
      for (int j = 0; j < 4; j++) begin
         tick();
         s0_bdone = 0; m1_bstart = 1;
         m1_wdata = 32'h1111_0000 + 32'(j); m1_addr = 32'h2000_0100 + 32'(4 * j);
         settle();
         chk($sformatf("b2b%0d m1_bgnt", j), m1_bgnt, 1);
         chk($sformatf("b2b%0d m0_bgnt", j), m0_bgnt, 0);
         chk($sformatf("b2b%0d s0_bstart", j), s0_bstart, 1);
         chk($sformatf("b2b%0d s0_wdata", j), s0_wdata, 32'h1111_0000 + 32'(j));
         chk($sformatf("b2b%0d s0_addr", j), s0_addr, 32'h2000_0100 + 32'(4 * j));
         tick();
         m1_bstart = 0; s0_bdone = 1; s0_rdata = 32'hC0DE_0000 + 32'(j);
         if (j == 3) m1_breq = 0;
         settle();
         chk($sformatf("b2b%0d m1_bdone", j), m1_bdone, 1);
         chk($sformatf("b2b%0d m1_rdata", j), m1_rdata, 32'hC0DE_0000 + 32'(j));
         chk($sformatf("b2b%0d m0_bdone", j), m0_bdone, 0);
         chk($sformatf("b2b%0d m0_bgnt xfer", j), m0_bgnt, 0);
         chk($sformatf("b2b%0d s0_wdata xfer", j), s0_wdata, 32'h1111_0000 + 32'(j));
      end
      tick(); s0_bdone = 0; settle();
      chk("b2b end s0_ss", s0_ss, 0);
      chk("b2b end m1_bgnt", m1_bgnt, 0);

`ifdef ARB_TIMEOUT_EN
      tick(); clr(); m0_breq = 1; m0_addr = A0; settle();
      tick(); m0_bstart = 1; m1_breq = 1; settle();
      chk("to bstart", s0_bstart, 1);
      for (int k = 1; k <= 8; k++) begin
         tick(); m0_bstart = 0; s0_rdata = 32'hBAD0_BAD0; settle();
         chk($sformatf("to c%0d m0_bdone", k), m0_bdone, (k == 8) ? 1 : 0);
         chk($sformatf("to c%0d m0_berror", k), m0_berror, (k == 8) ? 1 : 0);
         chk($sformatf("to c%0d m0_rdata", k), m0_rdata, 0);
         chk($sformatf("to c%0d m1_bdone", k), m1_bdone, 0);
      end
      tick(); m0_breq = 0; settle();
      chk("to idle m1_bgnt", m1_bgnt, 0);
      chk("to idle m0_berror", m0_berror, 0);
      chk("to idle s0_ss", s0_ss, 0);
      tick(); settle();
      chk("to next m1_bgnt", m1_bgnt, 1);
      tick(); m1_breq = 0; settle();
`endif

      // Randomized traffic against a transaction-level model.
      tick(); rst = 1; clr(); tick(); tick();
      rst = 0;
      ph[0] = 0; ph[1] = 0; sl_busy = 0; sl_cnt = 0; sl_who = 0; sl_addr = 0;
      exp_next = -1; issued = 0; done_n = 0;
      newtxn(0); newtxn(1);
      for (int cyc = 0; cyc < 3400; cyc++) begin
         bit stop;
         stop = (cyc >= 3000);
         tick();
         sl_fire = 0;
         if (sl_busy) begin
            if (sl_cnt == 0) sl_fire = 1;
            else sl_cnt--;
         end
         s0_bdone = sl_fire;
         s0_rdata = sl_fire ? (sl_addr ^ KEY) : $urandom();
         bgv = {m1_bgnt, m0_bgnt};
         for (int i = 0; i < 2; i++) begin
            bst[i] = 0;
            if (ph[i] == 0 && !stop && $urandom_range(0, 3) == 0) begin
               ph[i] = 1; newtxn(i);
            end else if (ph[i] == 1 && bgv[i]) begin
               bst[i] = 1; ph[i] = 2;
            end
            breq_d[i] = (ph[i] != 0);
         end
         m0_breq = breq_d[0]; m0_bstart = bst[0]; m0_addr = ma[0]; m0_wdata = mw[0];
         m0_ttype = mt[0]; m0_tsize = ms[0];
         m1_breq = breq_d[1]; m1_bstart = bst[1]; m1_addr = ma[1]; m1_wdata = mw[1];
         m1_ttype = mt[1]; m1_tsize = ms[1];
         settle();

         chk("rnd bgnt one-hot", m0_bgnt & m1_bgnt, 0);
         chk("rnd s0_bstart", s0_bstart, bst[0] | bst[1]);
         bdv = {m1_bdone, m0_bdone};
         erv = {m1_berror, m0_berror};
         rdv[0] = m0_rdata; rdv[1] = m1_rdata;
         for (int i = 0; i < 2; i++) begin
            logic ed;
            if (bst[i]) begin
               chk("rnd s0_addr", s0_addr, ma[i]);
               chk("rnd s0_wdata", s0_wdata, mw[i]);
               chk("rnd s0_ttype", s0_ttype, mt[i]);
               chk("rnd s0_tsize", s0_tsize, ms[i]);
               chk("rnd s0_ss", s0_ss, 1);
               if (exp_next >= 0) begin
                  chk("rnd round-robin order", i, exp_next);
                  exp_next = -1;
               end
            end
            ed = sl_fire && (sl_who == i[0]);
            chk($sformatf("rnd m%0d_bdone", i), bdv[i], ed);
            chk($sformatf("rnd m%0d_rdata", i), rdv[i], ed ? (ma[i] ^ KEY) : 32'h0);
            chk($sformatf("rnd m%0d_berror", i), erv[i], 0);
         end

         if (sl_fire) begin
            int w, o;
            w = int'(sl_who); o = 1 - w;
            sl_busy = 0; done_n++;
            exp_next = breq_d[o] ? o : -1;
            if (!stop && $urandom_range(0, 1) == 1) begin
               ph[w] = 1; newtxn(w);
            end else begin
               ph[w] = 0;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (bst[i]) begin
               sl_busy = 1; sl_who = i[0]; sl_addr = ma[i];
               sl_cnt = $urandom_range(0, 3); issued++;
            end
         end
         if (stop && ph[0] == 0 && ph[1] == 0 && !sl_busy) break;
      end
      chk("rnd drained", {30'd0, (ph[0] != 0), (ph[1] != 0) | sl_busy}, 0);
      chk("rnd completions", done_n, issued);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
